// File: rtl/nlfsr_pkg.sv
// Shared definitions for the NLFSR period engine: FSM state encoding and
// default widths.
package nlfsr_pkg;

    localparam int unsigned NLFSR_SIZE_DEF  = 32;
    localparam int unsigned NLFSR_CNT_W_DEF = 40;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nlfsr_period_cnt.sv
// Shift counter for a period run. Holds the shifts taken so far and the run
// limit captured at start; flags the shift that reaches the limit. A zero
// limit disables the compare and the count simply wraps.
module nlfsr_period_cnt #(
    parameter int CNT_W = 40
) (
    input  logic             clk,
    input  logic             res,
    input  logic             clear,
    input  logic             advance,
    input  logic [CNT_W-1:0] limit_in,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] count_next,
    output logic [CNT_W-1:0] limit,
    output logic             hit
);

    // Count register and captured limit.
    always_ff @(posedge clk) begin
        if (!res) begin
            count <= '0;
            limit <= '0;
        end else if (clear) begin
            count <= '0;
            limit <= limit_in;
        end else if (advance) begin
            count <= count_next;
        end
    end

    assign count_next = count + 1'b1;

    // Limit reached on the shift currently being taken.
    assign hit = (limit != '0) && (count_next == limit);

endmodule

// File: rtl/nlfsr_period_engine.sv
// Drives an external tap/XOR stage with the NLFSR state and measures how many
// shifts it takes to return to the seed, stopping early on an all-zero state
// or on the run limit.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | seeded or reset, waiting for start
//   RUN     | shifting one bit per cycle, tap stage enabled
//   DONE    | run finished; register, period and flags held for readout
module nlfsr_period_engine
    import nlfsr_pkg::*;
#(
    parameter int SIZE  = NLFSR_SIZE_DEF,
    parameter int CNT_W = NLFSR_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             res,
    input  logic             seed_load,
    input  logic [SIZE-1:0]  seed,
    input  logic             start,
    input  logic [CNT_W-1:0] max_cycles,
    input  logic             feedback,
    output logic [SIZE-1:0]  register,
    output logic             tap_en,
    output logic             out_bit,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] period,
    output logic             full_period,
    output logic             timeout,
    output logic             zero_lock
);

    if (SIZE < 4) begin : g_size_chk
        $error("nlfsr_period_engine: SIZE must be at least 4");
    end
    if (CNT_W <= SIZE) begin : g_cnt_chk
        $error("nlfsr_period_engine: CNT_W must exceed SIZE");
    end

    // 2^SIZE-1 expressed at counter width; CNT_W > SIZE so it always fits.
    localparam logic [CNT_W-1:0] FULL_CNT = {{(CNT_W-SIZE){1'b0}}, {SIZE{1'b1}}};

    state_t           state;
    state_t           state_next;
    logic [SIZE-1:0]  seed_reg;
    logic [SIZE-1:0]  shift_next;

    logic             do_load;
    logic             do_start;
    logic             do_zero_start;
    logic             do_shift;
    logic             end_match;
    logic             end_zero;
    logic             end_limit;

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] limit;
    logic             limit_hit;

    // Feedback arrives combinationally from the tap stage for the current
    // register value, so the next state is formed in the same cycle.
    assign shift_next = {register[SIZE-2:0], feedback};

    nlfsr_period_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk        (clk),
        .res        (res),
        .clear      (do_start),
        .advance    (do_shift),
        .limit_in   (max_cycles),
        .count      (cnt),
        .count_next (cnt_next),
        .limit      (limit),
        .hit        (limit_hit)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!res) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and datapath strobes; termination checks look at the
    // state about to be shifted in, with return-to-seed taking priority.
    always_comb begin
        state_next    = state;
        do_load       = 1'b0;
        do_start      = 1'b0;
        do_zero_start = 1'b0;
        do_shift      = 1'b0;
        end_match     = 1'b0;
        end_zero      = 1'b0;
        end_limit     = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (seed_load) begin
                    do_load    = 1'b1;
                    state_next = ST_IDLE;
                end else if (start) begin
                    if (register != '0) begin
                        do_start   = 1'b1;
                        state_next = ST_RUN;
                    end else begin
                        do_zero_start = 1'b1;
                        state_next    = ST_DONE;
                    end
                end
            end
            ST_RUN: begin
                do_shift = 1'b1;
                if (shift_next == seed_reg) begin
                    end_match  = 1'b1;
                    state_next = ST_DONE;
                end else if (shift_next == '0) begin
                    end_zero   = 1'b1;
                    state_next = ST_DONE;
                end else if (limit_hit) begin
                    end_limit  = 1'b1;
                    state_next = ST_DONE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // NLFSR state, seed copy, measured period and result flags.
    always_ff @(posedge clk) begin
        if (!res) begin
            register    <= '0;
            seed_reg    <= '0;
            period      <= '0;
            full_period <= 1'b0;
            timeout     <= 1'b0;
            zero_lock   <= 1'b0;
        end else begin
            if (do_load) begin
                register    <= seed;
                seed_reg    <= seed;
                period      <= '0;
                full_period <= 1'b0;
                timeout     <= 1'b0;
                zero_lock   <= 1'b0;
            end
            if (do_start) begin
                full_period <= 1'b0;
                timeout     <= 1'b0;
                zero_lock   <= 1'b0;
            end
            if (do_zero_start) begin
                period      <= '0;
                full_period <= 1'b0;
                timeout     <= 1'b0;
                zero_lock   <= 1'b1;
            end
            if (do_shift) begin
                register <= shift_next;
            end
            if (end_match) begin
                period      <= cnt_next;
                full_period <= (cnt_next == FULL_CNT);
            end
            if (end_zero) begin
                period    <= cnt_next;
                zero_lock <= 1'b1;
            end
            if (end_limit) begin
                period  <= limit;
                timeout <= 1'b1;
            end
        end
    end

    assign busy    = (state == ST_RUN);
    assign tap_en  = busy;
    assign done    = (state == ST_DONE);
    assign out_bit = register[SIZE-1];

endmodule

// File: doc/nlfsr_period_engine.md
NLFSR_PERIOD_ENGINE -- requirements
Module: nlfsr_period_engine

Interface
REQ-001 Parameter SIZE, default 32: NLFSR state width; minimum 4.
REQ-002 Parameter CNT_W, default 40: cycle-counter width; must be greater than SIZE.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 res  in  1  reset, synchronous, active-low.
REQ-005 seed_load  in  1  capture seed into state and seed_reg (accepted only when not busy).
REQ-006 seed  in  SIZE  initial NLFSR state.
REQ-007 start  in  1  begin a period run (accepted only in IDLE or DONE).
REQ-008 max_cycles  in  CNT_W  run limit; sampled on start.
REQ-009 feedback  in  1  combinational feedback bit from the downstream tap/XOR stage, computed from register.
REQ-010 register  out  SIZE  current NLFSR state, driven to the tap/XOR stage.
REQ-011 tap_en  out  1  high in RUN; drives the tap stage start input.
REQ-012 out_bit  out  1  register[SIZE-1], the generated stream bit.
REQ-013 busy  out  1  high in RUN.
REQ-014 done  out  1  high in DONE.
REQ-015 period  out  CNT_W  shifts until the state returned to seed_reg, or the shifts counted at termination.
REQ-016 full_period  out  1  done with period equal to 2^SIZE-1.
REQ-017 timeout  out  1  run ended at max_cycles without returning to seed_reg.
REQ-018 zero_lock  out  1  state was all-zero at start or became all-zero during the run.

Function
REQ-019 FSM states: IDLE, RUN, DONE; only these three.
REQ-020 IDLE/DONE + seed_load: register and seed_reg <= seed; clear period and all flags; go to IDLE.
REQ-021 seed_load and start in the same cycle: seed_load wins; start is ignored.
REQ-022 IDLE/DONE + start with register nonzero: cnt <= 0; limit <= max_cycles; clear flags; go to RUN.
REQ-023 IDLE/DONE + start with register zero: zero_lock <= 1, period <= 0; go to DONE next cycle.
REQ-024 In RUN, each cycle: register <= {register[SIZE-2:0], feedback}; cnt <= cnt+1.
REQ-025 Feedback is consumed in the cycle it is presented; the block adds no pipeline delay between register and feedback.
REQ-026 RUN termination priority, evaluated on the next state: (1) next == seed_reg -> period <= cnt+1, DONE; (2) next == 0 -> zero_lock, period <= cnt+1, DONE; (3) cnt+1 == limit -> timeout, period <= limit, DONE.
REQ-027 full_period is set in the same cycle as period when condition (1) holds and cnt+1 == 2^SIZE-1.
REQ-028 max_cycles == 0 means no limit; the counter wraps silently at 2^CNT_W.
REQ-029 In RUN, seed_load and start are ignored.
REQ-030 DONE holds register, period, and flags stable until seed_load or start.
REQ-031 done rises exactly one cycle after the terminating shift; the RUN-to-DONE transition takes 1 cycle.

Reset
REQ-032 When res is 0 at a rising edge: state IDLE; register, seed_reg, cnt, and period are 0; all flags are 0; tap_en, busy, and done are 0.
REQ-033 Reset asserted mid-RUN aborts the run within that cycle; no flag is set.

Structure
REQ-034 The package nlfsr_pkg holds the FSM state enum and the default SIZE and CNT_W constants.
REQ-035 The natural sub-module is nlfsr_period_cnt: the CNT_W counter with limit compare, returning the hit signal.
REQ-036 The tap/XOR stage is instantiated outside this block, at the level above it.

Verification (the bench models feedback = register[3]^register[2], SIZE=4, CNT_W=8)
REQ-037 seed_load with seed=4'b0001, then start, max_cycles=0 -> 15 shifts, then done=1, period=15, full_period=1, register=4'b0001.
REQ-038 seed=4'b0000, then start -> done after 1 cycle, zero_lock=1, period=0, busy never high.
REQ-039 seed=4'b0001, start, max_cycles=5 -> done=1, timeout=1, period=5, full_period=0.
REQ-040 seed_load and start asserted together with seed=4'b1000 -> register=4'b1000, state stays IDLE, busy=0.
REQ-041 res=0 at RUN cycle 7 -> next cycle all outputs are 0; then seed_load 4'b0001 and start -> period=15.
REQ-042 start pulsed during RUN -> ignored; the run still ends with period=15.
